// File: rtl/alu_sequencer.sv
// Issue/complete sequencer in front of a multi-cycle ALU.
// Accepts one op at a time, waits out the ALU, and resolves the writeback or branch outcome.
module alu_sequencer #(
    parameter int TIMEOUT = 40
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_valid,
    output logic        O_ready,
    input  logic [31:0] I_s1,
    input  logic [31:0] I_s2,
    input  logic [3:0]  I_aluop,
    input  logic [2:0]  I_funct3,
    input  logic        I_branch,
    input  logic [4:0]  I_rd,
    output logic        O_alu_en,
    output logic [31:0] O_alu_s1,
    output logic [31:0] O_alu_s2,
    output logic [3:0]  O_alu_op,
    input  logic        I_alu_busy,
    input  logic [31:0] I_alu_data,
    input  logic        I_alu_lt,
    input  logic        I_alu_ltu,
    input  logic        I_alu_eq,
    output logic        O_valid,
    input  logic        I_ready,
    output logic [31:0] O_wb_data,
    output logic [4:0]  O_rd,
    output logic        O_wb_en,
    output logic        O_taken,
    output logic        O_err
);

    // state | meaning
    // IDLE  | ready for a new op
    // ISSUE | operands presented to the ALU for one cycle
    // WAIT  | ALU busy; counting toward the timeout
    // DONE  | result held until the consumer takes it
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] s1_q, s1_d;
    logic [31:0] s2_q, s2_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        branch_q, branch_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        lt_q, lt_d;
    logic        ltu_q, ltu_d;
    logic        eq_q, eq_d;
    logic        err_q, err_d;
    logic        timeout_hit;
    logic        taken_cond;

    // The timeout cycle is the last WAIT cycle; busy is still high but the ALU is released.
    assign timeout_hit = (state_q == ST_WAIT) && I_alu_busy && (wait_cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        op_d       = op_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        branch_d   = branch_q;
        wb_data_d  = wb_data_q;
        lt_d       = lt_q;
        ltu_d      = ltu_q;
        eq_d       = eq_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (I_valid) begin
                    s1_d     = I_s1;
                    s2_d     = I_s2;
                    op_d     = I_aluop;
                    rd_d     = I_rd;
                    funct3_d = I_funct3;
                    branch_d = I_branch;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!I_alu_busy) begin
                    wb_data_d = I_alu_data;
                    lt_d      = I_alu_lt;
                    ltu_d     = I_alu_ltu;
                    eq_d      = I_alu_eq;
                    state_d   = ST_DONE;
                end else if (timeout_hit) begin
                    wb_data_d = 32'd0;
                    lt_d      = 1'b0;
                    ltu_d     = 1'b0;
                    eq_d      = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 6'd1;
                end
            end
            ST_DONE: begin
                if (I_ready) begin
                    err_d      = 1'b0;
                    wait_cnt_d = 6'd0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        taken_cond = 1'b0;
        case (funct3_q)
            3'b000:  taken_cond = eq_q;
            3'b001:  taken_cond = !eq_q;
            3'b100:  taken_cond = lt_q;
            3'b101:  taken_cond = !lt_q;
            3'b110:  taken_cond = ltu_q;
            3'b111:  taken_cond = !ltu_q;
            default: taken_cond = 1'b0;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 6'd0;
            s1_q       <= 32'd0;
            s2_q       <= 32'd0;
            op_q       <= 4'd0;
            rd_q       <= 5'd0;
            funct3_q   <= 3'd0;
            branch_q   <= 1'b0;
            wb_data_q  <= 32'd0;
            lt_q       <= 1'b0;
            ltu_q      <= 1'b0;
            eq_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            branch_q   <= branch_d;
            wb_data_q  <= wb_data_d;
            lt_q       <= lt_d;
            ltu_q      <= ltu_d;
            eq_q       <= eq_d;
            err_q      <= err_d;
        end
    end

    assign O_ready   = (state_q == ST_IDLE);
    assign O_valid   = (state_q == ST_DONE);
    assign O_alu_en  = (state_q == ST_ISSUE) || ((state_q == ST_WAIT) && I_alu_busy && !timeout_hit);
    assign O_alu_s1  = s1_q;
    assign O_alu_s2  = s2_q;
    assign O_alu_op  = op_q;
    assign O_wb_data = wb_data_q;
    assign O_rd      = rd_q;
    assign O_err     = err_q;
    // A timed-out branch carries no valid compare flags, so it never reports taken.
    assign O_taken   = (state_q == ST_DONE) && branch_q && !err_q && taken_cond;
    assign O_wb_en   = (state_q == ST_DONE) && !branch_q && (rd_q != 5'd0) && !err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small serial-shift ALU model.
module tb_alu_sequencer;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLL = 4'd2;
    localparam logic [3:0] OP_SRL = 4'd3;

    logic        clk;
    logic        I_reset, I_valid, I_branch, I_ready;
    logic [31:0] I_s1, I_s2;
    logic [3:0]  I_aluop;
    logic [2:0]  I_funct3;
    logic [4:0]  I_rd;
    logic        O_ready, O_alu_en, O_valid, O_wb_en, O_taken, O_err;
    logic [31:0] O_alu_s1, O_alu_s2, O_wb_data;
    logic [3:0]  O_alu_op;
    logic [4:0]  O_rd;
    logic        alu_busy, alu_lt, alu_ltu, alu_eq;
    logic [31:0] alu_data;
    logic        alu_run, force_busy;
    logic [4:0]  alu_cnt;

    int total = 0;
    int bad   = 0;

    alu_sequencer #(.TIMEOUT(40)) dut (
        .I_clk(clk), .I_reset(I_reset), .I_valid(I_valid), .O_ready(O_ready),
        .I_s1(I_s1), .I_s2(I_s2), .I_aluop(I_aluop), .I_funct3(I_funct3),
        .I_branch(I_branch), .I_rd(I_rd),
        .O_alu_en(O_alu_en), .O_alu_s1(O_alu_s1), .O_alu_s2(O_alu_s2), .O_alu_op(O_alu_op),
        .I_alu_busy(alu_busy), .I_alu_data(alu_data),
        .I_alu_lt(alu_lt), .I_alu_ltu(alu_ltu), .I_alu_eq(alu_eq),
        .O_valid(O_valid), .I_ready(I_ready),
        .O_wb_data(O_wb_data), .O_rd(O_rd), .O_wb_en(O_wb_en), .O_taken(O_taken), .O_err(O_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: combinational add/sub, shifts take n+1 busy cycles after the enable edge.
    always @(posedge clk) begin
        if (I_reset) begin
            alu_run <= 1'b0;
            alu_cnt <= 5'd0;
        end else if (alu_run) begin
            if (alu_cnt == 5'd0) alu_run <= 1'b0;
            else alu_cnt <= alu_cnt - 5'd1;
        end else if (O_alu_en && (O_alu_op == OP_SLL || O_alu_op == OP_SRL)) begin
            alu_run <= 1'b1;
            alu_cnt <= O_alu_s2[4:0];
        end
    end

    assign alu_busy = alu_run | force_busy;

    always_comb begin
        alu_data = 32'd0;
        case (O_alu_op)
            OP_ADD: alu_data = O_alu_s1 + O_alu_s2;
            OP_SUB: alu_data = O_alu_s1 - O_alu_s2;
            OP_SLL: alu_data = O_alu_s1 << O_alu_s2[4:0];
            OP_SRL: alu_data = O_alu_s1 >> O_alu_s2[4:0];
            default: alu_data = 32'd0;
        endcase
    end
    assign alu_lt  = $signed(O_alu_s1) < $signed(O_alu_s2);
    assign alu_ltu = O_alu_s1 < O_alu_s2;
    assign alu_eq  = O_alu_s1 == O_alu_s2;

    // Presents one op for a single accept edge; returns at the negedge of the ISSUE cycle.
    task automatic issue(input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] op,
                         input logic [2:0] f3, input logic br, input logic [4:0] rd);
        @(negedge clk);
        I_valid = 1'b1; I_s1 = s1; I_s2 = s2; I_aluop = op;
        I_funct3 = f3; I_branch = br; I_rd = rd;
        @(negedge clk);
        I_valid = 1'b0;
    endtask

    // Counts cycles after accept until O_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!O_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        I_reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (O_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", O_valid); end
        total++; if (O_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", O_ready); end
        total++; if (O_alu_en !== 1'b0) begin bad++; $display("FAIL rst_alu_en got=%b exp=0", O_alu_en); end
        total++; if ({O_wb_data, O_alu_s1, O_alu_s2} !== 96'd0) begin bad++; $display("FAIL rst_data got=%h/%h/%h exp=0", O_wb_data, O_alu_s1, O_alu_s2); end
        total++; if ({O_rd, O_alu_op, O_err, O_taken, O_wb_en} !== 12'd0) begin bad++; $display("FAIL rst_ctl got=%h exp=0", {O_rd, O_alu_op, O_err, O_taken, O_wb_en}); end
        I_reset = 1'b0;
        @(negedge clk);
        total++; if (O_ready !== 1'b1 || O_valid !== 1'b0) begin bad++; $display("FAIL rst_idle got=ready%b valid%b exp=ready1 valid0", O_ready, O_valid); end
    endtask

    task automatic test_add();
        int lat;
        issue(32'd5, 32'd7, OP_ADD, 3'b000, 1'b0, 5'd3);
        total++; if (O_alu_en !== 1'b1 || O_ready !== 1'b0) begin bad++; $display("FAIL add_issue got=en%b ready%b exp=en1 ready0", O_alu_en, O_ready); end
        total++; if (O_alu_s1 !== 32'd5 || O_alu_s2 !== 32'd7) begin bad++; $display("FAIL add_operands got=%h/%h exp=5/7", O_alu_s1, O_alu_s2); end
        wait_valid(lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL add_latency got=%0d exp=3", lat); end
        total++; if (O_wb_data !== 32'd12) begin bad++; $display("FAIL add_data got=%h exp=0000000c", O_wb_data); end
        total++; if (O_wb_en !== 1'b1 || O_taken !== 1'b0 || O_rd !== 5'd3) begin bad++; $display("FAIL add_ctl got=wb%b tk%b rd%0d exp=wb1 tk0 rd3", O_wb_en, O_taken, O_rd); end
        @(negedge clk);
        total++; if (O_ready !== 1'b1 || O_valid !== 1'b0) begin bad++; $display("FAIL add_return got=ready%b valid%b exp=ready1 valid0", O_ready, O_valid); end
        issue(32'd10, 32'd3, OP_SUB, 3'b000, 1'b0, 5'd0);
        wait_valid(lat);
        total++; if (O_wb_data !== 32'd7 || O_wb_en !== 1'b0) begin bad++; $display("FAIL sub_rd0 got=%h wb%b exp=00000007 wb0", O_wb_data, O_wb_en); end
        @(negedge clk);
    endtask

    task automatic test_branch();
        logic [2:0] f3_tab [8] = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111, 3'b010, 3'b100};
        logic       br_tab [8] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
        logic       tk_tab [8] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
        logic       wb_tab [8] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
        int lat;
        for (int i = 0; i < 8; i++) begin
            issue(32'hFFFF_FFFF, 32'd1, OP_SUB, f3_tab[i], br_tab[i], 5'd4);
            wait_valid(lat);
            total++; if (O_taken !== tk_tab[i] || O_wb_en !== wb_tab[i]) begin bad++; $display("FAIL branch_%0d got=tk%b wb%b exp=tk%b wb%b", i, O_taken, O_wb_en, tk_tab[i], wb_tab[i]); end
            total++; if (O_wb_data !== 32'hFFFF_FFFE || lat !== 3) begin bad++; $display("FAIL branch_data_%0d got=%h lat%0d exp=fffffffe lat3", i, O_wb_data, lat); end
            @(negedge clk);
        end
    endtask

    task automatic test_shift();
        int lat;
        issue(32'd1, 32'd31, OP_SLL, 3'b000, 1'b0, 5'd6);
        lat = 1;
        while (!O_valid && lat < 100) begin
            if (lat == 33) begin
                total++; if (O_alu_en !== 1'b1) begin bad++; $display("FAIL shift_en_busy got=%b exp=1", O_alu_en); end
            end
            if (lat == 34) begin
                total++; if (O_alu_en !== 1'b0) begin bad++; $display("FAIL shift_en_fall got=%b exp=0", O_alu_en); end
            end
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== 35) begin bad++; $display("FAIL shift31_latency got=%0d exp=35", lat); end
        total++; if (O_wb_data !== 32'h8000_0000 || O_wb_en !== 1'b1) begin bad++; $display("FAIL shift31_data got=%h wb%b exp=80000000 wb1", O_wb_data, O_wb_en); end
        @(negedge clk);
        issue(32'hA, 32'd0, OP_SLL, 3'b000, 1'b0, 5'd6);
        wait_valid(lat);
        total++; if (lat !== 4 || O_wb_data !== 32'hA) begin bad++; $display("FAIL shift0 got=lat%0d %h exp=lat4 0000000a", lat, O_wb_data); end
        @(negedge clk);
        issue(32'h8000_0000, 32'd4, OP_SRL, 3'b000, 1'b0, 5'd6);
        wait_valid(lat);
        total++; if (lat !== 8 || O_wb_data !== 32'h0800_0000) begin bad++; $display("FAIL srl4 got=lat%0d %h exp=lat8 08000000", lat, O_wb_data); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        I_ready = 1'b0;
        issue(32'd1, 32'd2, OP_ADD, 3'b000, 1'b0, 5'd7);
        wait_valid(lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (O_valid !== 1'b1 || O_ready !== 1'b0 || O_wb_data !== 32'd3 || O_rd !== 5'd7 ||
                O_wb_en !== 1'b1 || O_taken !== 1'b0 || O_err !== 1'b0 || O_alu_s1 !== 32'd1 || O_alu_en !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d got=v%b r%b d%h rd%0d wb%b tk%b err%b exp=v1 r0 d00000003 rd7 wb1 tk0 err0",
                         i, O_valid, O_ready, O_wb_data, O_rd, O_wb_en, O_taken, O_err);
            end
        end
        I_ready = 1'b1;
        @(negedge clk);
        total++; if (O_ready !== 1'b1 || O_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=ready%b valid%b exp=ready1 valid0", O_ready, O_valid); end
    endtask

    task automatic test_timeout();
        int lat;
        force_busy = 1'b1;
        issue(32'd4, 32'd4, OP_ADD, 3'b000, 1'b0, 5'd9);
        lat = 1;
        while (!O_valid && lat < 100) begin
            if (lat == 40) begin
                total++; if (O_alu_en !== 1'b1) begin bad++; $display("FAIL to_en_before got=%b exp=1", O_alu_en); end
            end
            if (lat == 41) begin
                total++; if (O_alu_en !== 1'b0) begin bad++; $display("FAIL to_en_drop got=%b exp=0", O_alu_en); end
            end
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== 42) begin bad++; $display("FAIL to_latency got=%0d exp=42", lat); end
        total++; if (O_err !== 1'b1 || O_wb_en !== 1'b0) begin bad++; $display("FAIL to_flags got=err%b wb%b exp=err1 wb0", O_err, O_wb_en); end
        force_busy = 1'b0;
        @(negedge clk);
        total++; if (O_err !== 1'b0 || O_ready !== 1'b1) begin bad++; $display("FAIL to_clear got=err%b ready%b exp=err0 ready1", O_err, O_ready); end
        // A long shift right after a timeout must not inherit the old wait count.
        issue(32'd3, 32'd31, OP_SLL, 3'b000, 1'b0, 5'd9);
        wait_valid(lat);
        total++; if (lat !== 35 || O_err !== 1'b0 || O_wb_data !== 32'h8000_0000) begin bad++; $display("FAIL to_after got=lat%0d err%b %h exp=lat35 err0 80000000", lat, O_err, O_wb_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        int lat;
        int spurious;
        issue(32'd1, 32'd20, OP_SLL, 3'b000, 1'b0, 5'd5);
        repeat (10) @(negedge clk);
        I_reset = 1'b1;
        @(negedge clk);
        I_reset = 1'b0;
        total++; if (O_ready !== 1'b1 || O_valid !== 1'b0 || O_alu_en !== 1'b0 || alu_busy !== 1'b0) begin bad++; $display("FAIL rst_shift got=r%b v%b en%b busy%b exp=r1 v0 en0 busy0", O_ready, O_valid, O_alu_en, alu_busy); end
        total++; if ({O_alu_s1, O_alu_s2, O_wb_data} !== 96'd0 || O_rd !== 5'd0 || O_alu_op !== 4'd0) begin bad++; $display("FAIL rst_shift_regs got=%h/%h op%h rd%0d exp=0", O_alu_s1, O_alu_s2, O_alu_op, O_rd); end
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (O_valid) spurious++;
        end
        total++; if (spurious !== 0) begin bad++; $display("FAIL rst_shift_stale got=%0d exp=0", spurious); end
        I_ready = 1'b0;
        issue(32'd8, 32'd9, OP_ADD, 3'b000, 1'b0, 5'd2);
        wait_valid(lat);
        total++; if (lat !== 3 || O_wb_data !== 32'd17) begin bad++; $display("FAIL rst_done_pre got=lat%0d %h exp=lat3 00000011", lat, O_wb_data); end
        I_reset = 1'b1;
        @(negedge clk);
        I_reset = 1'b0;
        total++; if (O_ready !== 1'b1 || O_valid !== 1'b0 || O_wb_en !== 1'b0 || O_err !== 1'b0) begin bad++; $display("FAIL rst_done got=r%b v%b wb%b err%b exp=r1 v0 wb0 err0", O_ready, O_valid, O_wb_en, O_err); end
        total++; if (O_wb_data !== 32'd0 || O_rd !== 5'd0 || O_alu_s1 !== 32'd0) begin bad++; $display("FAIL rst_done_regs got=%h rd%0d s1%h exp=0", O_wb_data, O_rd, O_alu_s1); end
        spurious = 0;
        repeat (6) begin
            @(negedge clk);
            if (O_valid) spurious++;
        end
        total++; if (spurious !== 0) begin bad++; $display("FAIL rst_done_stale got=%0d exp=0", spurious); end
        I_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        I_valid = 1'b1; I_s1 = 32'd2; I_s2 = 32'd3; I_aluop = OP_ADD;
        I_funct3 = 3'b000; I_branch = 1'b0; I_rd = 5'd1;
        @(negedge clk);
        // Held valid with a new payload must be ignored until the sequencer is idle again.
        I_s1 = 32'd100; I_s2 = 32'd200; I_rd = 5'd2;
        wait_valid(lat);
        total++; if (lat !== 3 || O_wb_data !== 32'd5 || O_rd !== 5'd1) begin bad++; $display("FAIL b2b_first got=lat%0d %h rd%0d exp=lat3 00000005 rd1", lat, O_wb_data, O_rd); end
        @(negedge clk);
        total++; if (O_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", O_ready); end
        @(negedge clk);
        I_valid = 1'b0;
        total++; if (O_alu_s1 !== 32'd100 || O_alu_en !== 1'b1) begin bad++; $display("FAIL b2b_second_issue got=%h en%b exp=00000064 en1", O_alu_s1, O_alu_en); end
        wait_valid(lat);
        total++; if (lat !== 3 || O_wb_data !== 32'd300 || O_rd !== 5'd2) begin bad++; $display("FAIL b2b_second got=lat%0d %h rd%0d exp=lat3 0000012c rd2", lat, O_wb_data, O_rd); end
        @(negedge clk);
    endtask

    initial begin
        I_reset = 1'b1; I_valid = 1'b0; I_ready = 1'b1; I_branch = 1'b0;
        I_s1 = 32'd0; I_s2 = 32'd0; I_aluop = 4'd0; I_funct3 = 3'd0; I_rd = 5'd0;
        force_busy = 1'b0;
        test_reset();
        test_add();
        test_branch();
        test_shift();
        test_backpressure();
        test_timeout();
        test_reset_inflight();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning the maximum number of WAIT cycles before an operation is abandoned.
REQ-002 SHALL have I_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have I_reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have I_valid input 1 / O_ready output 1: the issue handshake; a transfer occurs on the edge where both are high.
REQ-005 SHALL have I_s1, I_s2 input 32; I_aluop input 4; I_funct3 input 3; I_branch input 1; I_rd input 5: the issue payload.
REQ-006 SHALL have O_alu_en output 1; O_alu_s1, O_alu_s2 output 32; O_alu_op output 4: the drive to the ALU.
REQ-007 SHALL have I_alu_busy input 1; I_alu_data input 32; I_alu_lt, I_alu_ltu, I_alu_eq input 1: the ALU result and the registered compare flags.
REQ-008 SHALL have O_valid output 1 / I_ready input 1: the completion handshake.
REQ-009 SHALL have O_wb_data output 32; O_rd output 5; O_wb_en output 1; O_taken output 1; O_err output 1: the completion payload.

Function
REQ-010 SHALL implement the states IDLE, ISSUE, WAIT and DONE, encoded in 2 bits.
REQ-011 SHALL assert O_ready only in IDLE.
REQ-012 SHALL, on an issue transfer, register the full payload into O_alu_s1/s2/op and internal rd/funct3/branch, and move to ISSUE.
REQ-013 SHALL hold O_alu_s1/s2/op constant from ISSUE until return to IDLE.
REQ-014 SHALL drive O_alu_en combinationally high when in ISSUE, or when in WAIT with I_alu_busy=1, and low otherwise.
REQ-015 SHALL move from ISSUE to WAIT unconditionally after one cycle.
REQ-016 SHALL stay in WAIT, incrementing a 6-bit wait counter, while I_alu_busy=1.
REQ-017 SHALL, in WAIT with I_alu_busy=0, capture I_alu_data into O_wb_data and I_alu_lt/ltu/eq internally, then go to DONE.
REQ-018 SHALL, when the wait counter reaches TIMEOUT while in WAIT, go to DONE with O_err=1 and O_wb_en=0, and drop O_alu_en that cycle.
REQ-019 SHALL compute O_taken in DONE from I_branch and funct3, and force O_taken=0 when I_branch=0:
  - 000 -> eq
  - 001 -> !eq
  - 100 -> lt
  - 101 -> !lt
  - 110 -> ltu
  - 111 -> !ltu
  - 010/011 -> 0
REQ-020 SHALL set O_wb_en = !I_branch && rd!=0 && !O_err.
REQ-021 SHALL assert O_valid only in DONE, and hold every completion output stable while O_valid=1 and I_ready=0.
REQ-022 SHALL return to IDLE on the edge where O_valid and I_ready are both high, clearing O_err and the wait counter.
REQ-023 SHALL produce O_valid 3 cycles after the accept cycle for a non-shift op, and n+4 cycles after it for a shift by n (0..31).
REQ-024 SHALL ignore I_valid outside IDLE; no buffering, at most one op in flight.

Reset
REQ-025 SHALL, with I_reset=1 at a clock edge, go to IDLE with the following values, regardless of the current state:
  - O_valid=0, O_alu_en=0, O_err=0, O_taken=0, O_wb_en=0
  - O_wb_data=0, O_rd=0, O_alu_s1=0, O_alu_s2=0, O_alu_op=0
  - wait counter=0
REQ-026 SHALL give reset priority over both handshakes and the timeout.
REQ-027 SHALL share I_reset with the ALU, so an in-flight shift is abandoned with no stale completion afterwards.

Verification
REQ-028 ADD test: issue s1=5, s2=7, ADD, rd=3, I_ready=1 -> O_valid exactly 3 cycles after accept, O_wb_data=12, O_wb_en=1, O_taken=0.
REQ-029 BLT test: issue s1=0xFFFFFFFF, s2=1, SUB, branch=1, funct3=100 -> O_taken=1, O_wb_en=0; same operands with funct3=110 -> O_taken=0.
REQ-030 Shift test: SLL s1=1, s2=31 -> O_valid 35 cycles after accept, O_wb_data=0x80000000; O_alu_en low the cycle busy falls; shift by 0 -> latency 4.
REQ-031 Backpressure test: I_ready=0 for 5 cycles in DONE -> all outputs stable and O_ready=0; I_ready=1 -> IDLE next cycle and O_ready=1.
REQ-032 Timeout test: busy stubbed high -> O_valid with O_err=1, O_wb_en=0 after TIMEOUT WAIT cycles.
REQ-033 Reset test: reset mid-shift, and reset in DONE with I_ready=0 -> next cycle in IDLE, all outputs 0, O_ready=1, no spurious O_valid.
